// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg : opcode encoding and flag bit positions shared by the pipelined ALU
// Revision: 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_CMP = 3'd7
    } alu_op_t;

    // Bit positions inside the 4-bit {C, V, N, Z} flag vector
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_C = 3;

endpackage

`default_nettype wire

// File: rtl/alu_core.sv
// ============================================================================
// alu_core : combinational WIDTH-bit ALU producing a result and {C,V,N,Z} flags
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  alu_op_t          op_i,
    input  logic [WIDTH-1:0] rx_i,
    input  logic [WIDTH-1:0] ry_i,
    output logic [WIDTH-1:0] result_o,
    output logic [3:0]       flags_o
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] C_WIDTH = WIDTH'(WIDTH);

    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_diff;
    logic [2*WIDTH-1:0]   w_shl;
    logic [2*WIDTH-1:0]   w_shr;
    logic [SHW-1:0]       w_amt;
    logic                 w_big;
    logic                 w_c;
    logic                 w_v;
    logic                 w_n_en;
    logic                 w_known;

    assign w_amt  = ry_i[SHW-1:0];
    assign w_big  = (ry_i >= C_WIDTH);
    assign w_sum  = {1'b0, rx_i} + {1'b0, ry_i};
    assign w_diff = {1'b0, rx_i} - {1'b0, ry_i};
    // Double-width shifts keep the last bit shifted out adjacent to the result
    assign w_shl  = {{WIDTH{1'b0}}, rx_i} << w_amt;
    assign w_shr  = {rx_i, {WIDTH{1'b0}}} >> w_amt;

    always_comb begin
        result_o = '0;
        flags_o  = '0;
        w_c      = 1'b0;
        w_v      = 1'b0;
        w_n_en   = 1'b1;
        w_known  = 1'b1;
        case (op_i)
            OP_ADD: begin
                result_o = w_sum[WIDTH-1:0];
                w_c      = w_sum[WIDTH];
                w_v      = (rx_i[WIDTH-1] == ry_i[WIDTH-1]) &&
                           (w_sum[WIDTH-1] != rx_i[WIDTH-1]);
            end
            OP_SUB: begin
                result_o = w_diff[WIDTH-1:0];
                w_c      = w_diff[WIDTH];
                w_v      = (rx_i[WIDTH-1] != ry_i[WIDTH-1]) &&
                           (w_diff[WIDTH-1] != rx_i[WIDTH-1]);
            end
            OP_AND: result_o = rx_i & ry_i;
            OP_OR:  result_o = rx_i | ry_i;
            OP_XOR: result_o = rx_i ^ ry_i;
            OP_SHL: begin
                if (w_big) begin
                    w_c = (ry_i == C_WIDTH) && rx_i[0];
                end else begin
                    result_o = w_shl[WIDTH-1:0];
                    w_c      = w_shl[WIDTH];
                end
            end
            OP_SHR: begin
                if (w_big) begin
                    w_c = (ry_i == C_WIDTH) && rx_i[WIDTH-1];
                end else begin
                    result_o = w_shr[2*WIDTH-1:WIDTH];
                    w_c      = w_shr[WIDTH-1];
                end
            end
            OP_CMP: begin
                w_n_en = 1'b0;
                if (rx_i == ry_i) begin
                    result_o = '0;
                end else if (rx_i > ry_i) begin
                    result_o = WIDTH'(1);
                end else begin
                    result_o = WIDTH'(2);
                end
            end
            default: w_known = 1'b0;
        endcase

        if (w_known) begin
            flags_o[FLAG_Z] = (result_o == '0);
            flags_o[FLAG_N] = w_n_en && result_o[WIDTH-1];
            flags_o[FLAG_V] = w_v;
            flags_o[FLAG_C] = w_c;
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_pipe.sv
// ============================================================================
// alu_pipe : two-stage valid/ready pipelined ALU (capture stage, execute stage)
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  alu_op_t          in_op,
    input  logic [WIDTH-1:0] in_rx,
    input  logic [WIDTH-1:0] in_ry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags
);

    logic             s1_valid_q;
    logic             s1_valid_d;
    alu_op_t          s1_op_q;
    logic [WIDTH-1:0] s1_rx_q;
    logic [WIDTH-1:0] s1_ry_q;
    logic             out_valid_q;
    logic             out_valid_d;
    logic [WIDTH-1:0] out_result_q;
    logic [3:0]       out_flags_q;

    logic [WIDTH-1:0] w_core_result;
    logic [3:0]       w_core_flags;
    logic             w_stage2_free;
    logic             w_in_fire;
    logic             w_s2_load;
    logic             w_out_fire;

    // in_ready depends only on pipeline state and out_ready, never on in_valid
    assign w_stage2_free = !out_valid_q || out_ready;
    assign in_ready      = !s1_valid_q || w_stage2_free;
    assign w_in_fire     = in_valid && in_ready;
    assign w_s2_load     = s1_valid_q && w_stage2_free;
    assign w_out_fire    = out_valid_q && out_ready;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op_i     (s1_op_q),
        .rx_i     (s1_rx_q),
        .ry_i     (s1_ry_q),
        .result_o (w_core_result),
        .flags_o  (w_core_flags)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        if (w_in_fire) begin
            s1_valid_d = 1'b1;
        end else if (w_s2_load) begin
            s1_valid_d = 1'b0;
        end

        out_valid_d = out_valid_q;
        if (w_s2_load) begin
            out_valid_d = 1'b1;
        end else if (w_out_fire) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_op_q      <= OP_ADD;
            s1_rx_q      <= '0;
            s1_ry_q      <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_flags_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            if (w_in_fire) begin
                s1_op_q <= in_op;
                s1_rx_q <= in_rx;
                s1_ry_q <= in_ry;
            end
            if (w_s2_load) begin
                out_result_q <= w_core_result;
                out_flags_q  <= w_core_flags;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_flags  = out_flags_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_pipe.sv
// ============================================================================
// tb_alu_pipe : directed and randomised checks of alu_pipe at WIDTH 8 and 32
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_pipe;
    import alu_pkg::*;

    logic        clk;
    logic        rst;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    alu_op_t     a_in_op;
    logic [7:0]  a_in_rx, a_in_ry, a_out_result;
    logic [3:0]  a_out_flags;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    alu_op_t     b_in_op;
    logic [31:0] b_in_rx, b_in_ry, b_out_result;
    logic [3:0]  b_out_flags;

    int checks;
    int failures;
    int out_count;
    logic [67:0] exp_q[$];

    alu_pipe #(.WIDTH(8)) dut8 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (a_in_valid),
        .in_ready   (a_in_ready),
        .in_op      (a_in_op),
        .in_rx      (a_in_rx),
        .in_ry      (a_in_ry),
        .out_valid  (a_out_valid),
        .out_ready  (a_out_ready),
        .out_result (a_out_result),
        .out_flags  (a_out_flags)
    );

    alu_pipe #(.WIDTH(32)) dut32 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (b_in_valid),
        .in_ready   (b_in_ready),
        .in_op      (b_in_op),
        .in_rx      (b_in_rx),
        .in_ry      (b_in_ry),
        .out_valid  (b_out_valid),
        .out_ready  (b_out_ready),
        .out_result (b_out_result),
        .out_flags  (b_out_flags)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: returns {C,V,N,Z, result[63:0]} for a w-bit ALU
    function automatic logic [67:0] ref_alu(logic [2:0] op, logic [63:0] a_in,
                                            logic [63:0] b_in, int w);
        logic [63:0] mask, a, b, r;
        logic [64:0] s;
        logic        c, v, n, z;
        int          sh;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        a = a_in & mask;
        b = b_in & mask;
        r = 64'd0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[63:0] & mask;
                c = s[w];
                v = (a[w-1] == b[w-1]) && (r[w-1] != a[w-1]);
            end
            3'd1: begin
                r = (a - b) & mask;
                c = (a < b);
                v = (a[w-1] != b[w-1]) && (r[w-1] != a[w-1]);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: begin
                if (b >= 64'(w)) begin
                    c = (b == 64'(w)) ? a[0] : 1'b0;
                end else begin
                    sh = int'(b);
                    r  = (a << sh) & mask;
                    c  = (sh == 0) ? 1'b0 : a[w-sh];
                end
            end
            3'd6: begin
                if (b >= 64'(w)) begin
                    c = (b == 64'(w)) ? a[w-1] : 1'b0;
                end else begin
                    sh = int'(b);
                    r  = a >> sh;
                    c  = (sh == 0) ? 1'b0 : a[sh-1];
                end
            end
            default: r = (a == b) ? 64'd0 : ((a > b) ? 64'd1 : 64'd2);
        endcase
        n = (op == 3'd7) ? 1'b0 : r[w-1];
        z = (r == 64'd0);
        return {c, v, n, z, r};
    endfunction

    task automatic drive(int w, logic iv, logic [2:0] op, logic [63:0] rx,
                         logic [63:0] ry, logic ordy);
        if (w == 8) begin
            a_in_valid  = iv;
            a_in_op     = alu_op_t'(op);
            a_in_rx     = rx[7:0];
            a_in_ry     = ry[7:0];
            a_out_ready = ordy;
        end else begin
            b_in_valid  = iv;
            b_in_op     = alu_op_t'(op);
            b_in_rx     = rx[31:0];
            b_in_ry     = ry[31:0];
            b_out_ready = ordy;
        end
    endtask

    // One clock of scoreboard traffic; inputs already driven after a negedge
    task automatic step(int w, output logic ir, output logic ov, output logic [63:0] res);
        logic        iv, ordy;
        logic [2:0]  op;
        logic [63:0] rx, ry;
        logic [3:0]  fl;
        logic [67:0] e;
        #1;
        if (w == 8) begin
            iv = a_in_valid; ir = a_in_ready; op = a_in_op;
            rx = {56'd0, a_in_rx}; ry = {56'd0, a_in_ry};
            ov = a_out_valid; ordy = a_out_ready;
            res = {56'd0, a_out_result}; fl = a_out_flags;
        end else begin
            iv = b_in_valid; ir = b_in_ready; op = b_in_op;
            rx = {32'd0, b_in_rx}; ry = {32'd0, b_in_ry};
            ov = b_out_valid; ordy = b_out_ready;
            res = {32'd0, b_out_result}; fl = b_out_flags;
        end
        if (ov && ordy) begin
            if (exp_q.size() == 0) begin
                check("sb_spurious_out", {63'd0, ov}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_result", res, e[63:0]);
                check("sb_flags", {60'd0, fl}, {60'd0, e[67:64]});
                out_count++;
            end
        end
        if (iv && ir) exp_q.push_back(ref_alu(op, rx, ry, w));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic directed(string tag, alu_op_t op, logic [7:0] rx, logic [7:0] ry,
                            logic [7:0] er, logic [3:0] ef, logic [3:0] fm);
        a_in_valid = 1'b1; a_in_op = op; a_in_rx = rx; a_in_ry = ry; a_out_ready = 1'b1;
        #1 check({tag, "_in_ready"}, {63'd0, a_in_ready}, 64'd1);
        @(posedge clk); @(negedge clk);
        a_in_valid = 1'b0;
        #1 check({tag, "_early_valid"}, {63'd0, a_out_valid}, 64'd0);
        @(posedge clk); @(negedge clk);
        #1;
        check({tag, "_valid"}, {63'd0, a_out_valid}, 64'd1);
        check({tag, "_result"}, {56'd0, a_out_result}, {56'd0, er});
        check({tag, "_flags"}, {60'd0, a_out_flags & fm}, {60'd0, ef});
        @(posedge clk); @(negedge clk);
    endtask

    initial begin
        logic        ir, ov;
        logic [63:0] res, rx, ry;
        int          k, acc, oc0;
        logic [2:0]  bp_op [4];
        logic [7:0]  bp_rx [4];
        logic [7:0]  bp_ry [4];

        checks = 0; failures = 0; out_count = 0;
        rst = 1'b1;
        drive(8, 1'b0, 3'd0, 64'd0, 64'd0, 1'b1);
        drive(32, 1'b0, 3'd0, 64'd0, 64'd0, 1'b1);
        repeat (3) @(negedge clk);
        check("rst_a_valid", {63'd0, a_out_valid}, 64'd0);
        check("rst_a_result", {56'd0, a_out_result}, 64'd0);
        check("rst_a_flags", {60'd0, a_out_flags}, 64'd0);
        check("rst_b_valid", {63'd0, b_out_valid}, 64'd0);
        rst = 1'b0;
        #1 check("post_rst_in_ready", {63'd0, a_in_ready}, 64'd1);
        @(posedge clk); @(negedge clk);

        // flags are {C,V,N,Z}
        directed("add_ff_01", OP_ADD, 8'hFF, 8'h01, 8'h00, 4'b1001, 4'hF);
        directed("add_7f_01", OP_ADD, 8'h7F, 8'h01, 8'h80, 4'b0110, 4'hF);
        directed("sub_03_05", OP_SUB, 8'h03, 8'h05, 8'hFE, 4'b1010, 4'hF);
        directed("sub_80_01", OP_SUB, 8'h80, 8'h01, 8'h7F, 4'b0100, 4'hF);
        directed("cmp_eq",    OP_CMP, 8'h05, 8'h05, 8'h00, 4'b0001, 4'hF);
        directed("cmp_gt",    OP_CMP, 8'h09, 8'h02, 8'h01, 4'b0000, 4'hF);
        directed("cmp_lt",    OP_CMP, 8'h02, 8'h09, 8'h02, 4'b0000, 4'hF);
        directed("shl_81_1",  OP_SHL, 8'h81, 8'h01, 8'h02, 4'b1000, 4'hF);
        directed("shr_81_8",  OP_SHR, 8'h81, 8'h08, 8'h00, 4'b0001, 4'b0111);
        directed("shl_5a_0",  OP_SHL, 8'h5A, 8'h00, 8'h5A, 4'b0000, 4'hF);
        directed("and",       OP_AND, 8'hF0, 8'h3C, 8'h30, 4'b0000, 4'hF);
        directed("or",        OP_OR,  8'h80, 8'h01, 8'h81, 4'b0010, 4'hF);
        directed("xor_zero",  OP_XOR, 8'hAA, 8'hAA, 8'h00, 4'b0001, 4'hF);

        // Reset with two ops in flight
        drive(8, 1'b1, 3'd0, 64'd1, 64'd2, 1'b0);
        @(posedge clk); @(negedge clk);
        drive(8, 1'b1, 3'd1, 64'd9, 64'd4, 1'b0);
        @(posedge clk); @(negedge clk);
        #1 check("pre_rst_valid", {63'd0, a_out_valid}, 64'd1);
        rst = 1'b1;
        #1;
        check("midrst_valid", {63'd0, a_out_valid}, 64'd0);
        check("midrst_result", {56'd0, a_out_result}, 64'd0);
        check("midrst_flags", {60'd0, a_out_flags}, 64'd0);
        drive(8, 1'b0, 3'd0, 64'd0, 64'd0, 1'b1);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check("post_midrst_no_stale", {63'd0, a_out_valid}, 64'd0);
            @(posedge clk); @(negedge clk);
        end

        // Backpressure: four back-to-back ops against a stalled consumer
        bp_op[0] = 3'd0; bp_rx[0] = 8'd10;  bp_ry[0] = 8'd20;
        bp_op[1] = 3'd1; bp_rx[1] = 8'd50;  bp_ry[1] = 8'd8;
        bp_op[2] = 3'd4; bp_rx[2] = 8'h0F;  bp_ry[2] = 8'hFF;
        bp_op[3] = 3'd6; bp_rx[3] = 8'h80;  bp_ry[3] = 8'd3;
        k = 0;
        oc0 = out_count;
        for (int cyc = 0; cyc < 6; cyc++) begin
            drive(8, 1'b1, bp_op[k], {56'd0, bp_rx[k]}, {56'd0, bp_ry[k]}, 1'b0);
            step(8, ir, ov, res);
            if (cyc < 3) check("bp_in_ready", {63'd0, ir}, (cyc < 2) ? 64'd1 : 64'd0);
            if (cyc >= 2) begin
                check("bp_hold_valid", {63'd0, ov}, 64'd1);
                check("bp_hold_result", res, 64'h1E);
            end
            if (ir) k++;
        end
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (k < 4) drive(8, 1'b1, bp_op[k], {56'd0, bp_rx[k]}, {56'd0, bp_ry[k]}, 1'b1);
            else       drive(8, 1'b0, 3'd0, 64'd0, 64'd0, 1'b1);
            step(8, ir, ov, res);
            if (ir && k < 4) k++;
        end
        check("bp_out_count", 64'(out_count - oc0), 64'd4);
        check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

        // Random traffic on both widths
        for (int wi = 0; wi < 2; wi++) begin
            automatic int w = (wi == 0) ? 8 : 32;
            for (int cyc = 0; cyc < 400; cyc++) begin
                rx = {$urandom, $urandom};
                ry = ($urandom_range(0, 1) == 1) ? 64'($urandom_range(0, w + 2)) : {$urandom, $urandom};
                drive(w, $urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), rx, ry,
                      $urandom_range(0, 9) < 7);
                step(w, ir, ov, res);
            end
            for (int cyc = 0; cyc < 5; cyc++) begin
                drive(w, 1'b0, 3'd0, 64'd0, 64'd0, 1'b1);
                step(w, ir, ov, res);
            end
            check("rand_drained", 64'(exp_q.size()), 64'd0);
        end

        // Full throughput with both sides always ready
        acc = 0;
        oc0 = out_count;
        for (int cyc = 0; cyc < 20; cyc++) begin
            drive(32, 1'b1, 3'($urandom_range(0, 7)), {32'd0, $urandom},
                  64'($urandom_range(0, 40)), 1'b1);
            step(32, ir, ov, res);
            if (ir) acc++;
        end
        check("tput_accepts", 64'(acc), 64'd20);
        check("tput_outputs", 64'(out_count - oc0), 64'd18);
        for (int cyc = 0; cyc < 4; cyc++) begin
            drive(32, 1'b0, 3'd0, 64'd0, 64'd0, 1'b1);
            step(32, ir, ov, res);
        end
        check("tput_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
